// File: rtl/dsp_fetch_seq.sv
// Program-counter and instruction fetch unit between a one-cycle synchronous ROM and Decode.
// Latency: address in cycle N, instruction_out/inst_valid/inst_pc in cycle N+1; loop-back adds no bubble.
// Backpressure: stall freezes PC, loop state and the Decode side-band; jumps squash exactly one fetch.
//
// Optional feature: define FETCH_HWLOOP_EN to build the zero-overhead hardware loop.
// Without it the loop ports are ignored and loop_active is tied low.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   stall               hold fetch (jump_flag / loop_start ignored while high)
//   jump_flag/addr      redirect PC; the in-flight fetch is squashed
//   loop_start/end/cnt  arm the hardware loop (pulse from Decode)
//   read_addr/en/data   ROM port; read_data arrives one cycle after read_addr
//   instruction_out     pass-through of read_data, qualified by inst_valid/inst_pc
//   loop_active         hardware loop armed
module dsp_fetch_seq #(
    parameter int                ADDR_W     = 16,
    parameter int                INST_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                LOOP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  jump_flag,
    input  logic [ADDR_W-1:0]     jump_addr,
    input  logic                  loop_start,
    input  logic [ADDR_W-1:0]     loop_end_addr,
    input  logic [LOOP_CNT_W-1:0] loop_count,
    output logic [ADDR_W-1:0]     read_addr,
    output logic                  read_en,
    input  logic [INST_W-1:0]     read_data,
    output logic [INST_W-1:0]     instruction_out,
    output logic                  inst_valid,
    output logic [ADDR_W-1:0]     inst_pc,
    output logic                  loop_active
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;

    // Loop-back request for this cycle; already qualified by stall and jump_flag.
    logic              loop_back;
    logic [ADDR_W-1:0] loop_begin;

`ifdef FETCH_HWLOOP_EN
    logic [ADDR_W-1:0]     loop_begin_q, loop_begin_d;
    logic [ADDR_W-1:0]     loop_end_q, loop_end_d;
    logic [LOOP_CNT_W-1:0] loop_remaining_q, loop_remaining_d;
    logic                  loop_active_q, loop_active_d;
    logic                  loop_arm;
    logic                  loop_hit;

    always_comb begin
        loop_begin_d     = loop_begin_q;
        loop_end_d       = loop_end_q;
        loop_remaining_d = loop_remaining_q;
        loop_active_d    = loop_active_q;
        loop_back        = 1'b0;

        loop_arm = loop_start & ~stall & ~jump_flag;
        loop_hit = loop_active_q & (pc_q == loop_end_q) & ~stall & ~jump_flag;

        // Re-arm has priority over a loop-back at the same address; the PC then
        // simply advances because loop_back stays low.
        if (loop_arm) begin
            loop_begin_d = pc_q;
            loop_end_d   = loop_end_addr;
            if (loop_count >= LOOP_CNT_W'(2)) begin
                loop_active_d    = 1'b1;
                loop_remaining_d = loop_count;
            end else begin
                loop_active_d    = 1'b0;
                loop_remaining_d = '0;
            end
        end else if (loop_hit) begin
            if (loop_remaining_q > LOOP_CNT_W'(1)) begin
                loop_back        = 1'b1;
                loop_remaining_d = loop_remaining_q - LOOP_CNT_W'(1);
            end else begin
                loop_active_d    = 1'b0;
                loop_remaining_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            loop_begin_q     <= '0;
            loop_end_q       <= '0;
            loop_remaining_q <= '0;
            loop_active_q    <= 1'b0;
        end else begin
            loop_begin_q     <= loop_begin_d;
            loop_end_q       <= loop_end_d;
            loop_remaining_q <= loop_remaining_d;
            loop_active_q    <= loop_active_d;
        end
    end

    assign loop_begin  = loop_begin_q;
    assign loop_active = loop_active_q;
`else
    logic loop_ports_unused;
    assign loop_ports_unused = ^{loop_start, loop_end_addr, loop_count};
    assign loop_back         = 1'b0;
    assign loop_begin        = '0;
    assign loop_active       = 1'b0;
`endif

    always_comb begin
        pc_d         = pc_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        if (!stall) begin
            inst_pc_d    = pc_q;
            // The word fetched this cycle is on the wrong path if we jump now.
            inst_valid_d = ~jump_flag;
            if (jump_flag) begin
                pc_d = jump_addr;
            end else if (loop_back) begin
                pc_d = loop_begin;
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign read_addr       = pc_q;
    assign read_en         = rst & ~stall;
    assign instruction_out = read_data;
    assign inst_valid      = inst_valid_q;
    assign inst_pc         = inst_pc_q;

endmodule

// File: tb/tb_dsp_fetch_seq.sv
module tb_dsp_fetch_seq;

    localparam int                ADDR_W = 16;
    localparam int                INST_W = 32;
    localparam logic [ADDR_W-1:0] RST_PC = 16'h0010;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              jump_flag;
    logic [15:0]       jump_addr;
    logic              loop_start;
    logic [15:0]       loop_end_addr;
    logic [15:0]       loop_count;
    logic [15:0]       read_addr;
    logic              read_en;
    logic [31:0]       read_data;
    logic [31:0]       instruction_out;
    logic              inst_valid;
    logic [15:0]       inst_pc;
    logic              loop_active;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dsp_fetch_seq #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RST_PC), .LOOP_CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .jump_flag(jump_flag), .jump_addr(jump_addr),
        .loop_start(loop_start), .loop_end_addr(loop_end_addr), .loop_count(loop_count),
        .read_addr(read_addr), .read_en(read_en), .read_data(read_data),
        .instruction_out(instruction_out), .inst_valid(inst_valid),
        .inst_pc(inst_pc), .loop_active(loop_active)
    );

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    // ROM model: one-cycle read latency, output register holds while read_en=0.
    always @(posedge clk) begin
        if (read_en) read_data <= rom_word(read_addr);
    end

    typedef struct {
        logic        st;
        logic        jf;
        logic [15:0] ja;
        logic        ls;
        logic [15:0] le;
        logic [15:0] lc;
        logic [15:0] e_addr;
        logic        e_en;
        logic        e_vld;
        logic [15:0] e_ipc;
        logic        e_la;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic jf, input logic [15:0] ja,
                                input logic ls, input logic [15:0] le, input logic [15:0] lc,
                                input logic [15:0] ea, input logic een, input logic evld,
                                input logic [15:0] eipc, input logic ela);
        vec_t v;
        v.st = st; v.jf = jf; v.ja = ja; v.ls = ls; v.le = le; v.lc = lc;
        v.e_addr = ea; v.e_en = een; v.e_vld = evld; v.e_ipc = eipc; v.e_la = ela;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let them settle.
    task automatic drive(input logic r, input logic st, input logic jf, input logic [15:0] ja,
                         input logic ls, input logic [15:0] le, input logic [15:0] lc);
        @(negedge clk);
        rst = r; stall = st; jump_flag = jf; jump_addr = ja;
        loop_start = ls; loop_end_addr = le; loop_count = lc;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    logic la_exp;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; stall = 1'b0; jump_flag = 1'b0; jump_addr = '0;
        loop_start = 1'b0; loop_end_addr = '0; loop_count = '0;

        // Directed cycle table, starting with the first cycle after reset release.
        vecs.push_back(mk(0,0,16'h0,   0,16'h0,16'h0, 16'h0010,1,0,16'h0000,0));
        vecs.push_back(mk(0,0,16'h0,   0,16'h0,16'h0, 16'h0011,1,1,16'h0010,0));
        vecs.push_back(mk(0,0,16'h0,   0,16'h0,16'h0, 16'h0012,1,1,16'h0011,0));
        vecs.push_back(mk(0,0,16'h0,   0,16'h0,16'h0, 16'h0013,1,1,16'h0012,0));
        vecs.push_back(mk(0,0,16'h0,   0,16'h0,16'h0, 16'h0014,1,1,16'h0013,0));
        vecs.push_back(mk(0,1,16'h0200,0,16'h0,16'h0, 16'h0015,1,1,16'h0014,0));
        vecs.push_back(mk(0,0,16'h0,   0,16'h0,16'h0, 16'h0200,1,0,16'h0015,0));
        vecs.push_back(mk(0,1,16'h002E,0,16'h0,16'h0, 16'h0201,1,1,16'h0200,0));
        vecs.push_back(mk(0,0,16'h0,   0,16'h0,16'h0, 16'h002E,1,0,16'h0201,0));
        vecs.push_back(mk(0,0,16'h0,   0,16'h0,16'h0, 16'h002F,1,1,16'h002E,0));
        vecs.push_back(mk(1,0,16'h0,   0,16'h0,16'h0, 16'h0030,0,1,16'h002F,0));
        vecs.push_back(mk(1,1,16'h0300,0,16'h0,16'h0, 16'h0030,0,1,16'h002F,0));
        vecs.push_back(mk(1,0,16'h0,   1,16'h0031,16'd3, 16'h0030,0,1,16'h002F,0));
        vecs.push_back(mk(1,0,16'h0,   0,16'h0,16'h0, 16'h0030,0,1,16'h002F,0));
        vecs.push_back(mk(0,0,16'h0,   0,16'h0,16'h0, 16'h0030,1,1,16'h002F,0));
        vecs.push_back(mk(0,1,16'h0040,0,16'h0,16'h0, 16'h0031,1,1,16'h0030,0));
        vecs.push_back(mk(0,0,16'h0,   1,16'h0042,16'd3, 16'h0040,1,0,16'h0031,0));
`ifdef FETCH_HWLOOP_EN
        vecs.push_back(mk(0,0,16'h0,0,16'h0,16'h0, 16'h0041,1,1,16'h0040,1));
        vecs.push_back(mk(0,0,16'h0,0,16'h0,16'h0, 16'h0042,1,1,16'h0041,1));
        vecs.push_back(mk(0,0,16'h0,0,16'h0,16'h0, 16'h0040,1,1,16'h0042,1));
        vecs.push_back(mk(0,0,16'h0,0,16'h0,16'h0, 16'h0041,1,1,16'h0040,1));
        vecs.push_back(mk(0,0,16'h0,0,16'h0,16'h0, 16'h0042,1,1,16'h0041,1));
        vecs.push_back(mk(0,0,16'h0,0,16'h0,16'h0, 16'h0040,1,1,16'h0042,1));
        vecs.push_back(mk(0,0,16'h0,0,16'h0,16'h0, 16'h0041,1,1,16'h0040,1));
        vecs.push_back(mk(0,0,16'h0,0,16'h0,16'h0, 16'h0042,1,1,16'h0041,1));
        vecs.push_back(mk(0,0,16'h0,0,16'h0,16'h0, 16'h0043,1,1,16'h0042,0));
        vecs.push_back(mk(0,0,16'h0,0,16'h0,16'h0, 16'h0044,1,1,16'h0043,0));
`else
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(0,0,16'h0,0,16'h0,16'h0,
                              16'h0041 + 16'(i), 1, 1, 16'h0040 + 16'(i), 0));
        end
`endif

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
            if (i > 0) chk("rst_read_addr", 32'(read_addr), 32'(RST_PC));
            chk("rst_read_en", 32'(read_en), 32'd0);
            if (i > 0) begin
                chk("rst_inst_valid", 32'(inst_valid), 32'd0);
                chk("rst_inst_pc", 32'(inst_pc), 32'd0);
                chk("rst_loop_active", 32'(loop_active), 32'd0);
            end
        end

        foreach (vecs[k]) begin
            drive(1'b1, vecs[k].st, vecs[k].jf, vecs[k].ja, vecs[k].ls, vecs[k].le, vecs[k].lc);
            chk($sformatf("v%0d_read_addr", k), 32'(read_addr), 32'(vecs[k].e_addr));
            chk($sformatf("v%0d_read_en", k), 32'(read_en), 32'(vecs[k].e_en));
            chk($sformatf("v%0d_inst_valid", k), 32'(inst_valid), 32'(vecs[k].e_vld));
            chk($sformatf("v%0d_inst_pc", k), 32'(inst_pc), 32'(vecs[k].e_ipc));
            chk($sformatf("v%0d_loop_active", k), 32'(loop_active), 32'(vecs[k].e_la));
            if (vecs[k].e_vld)
                chk($sformatf("v%0d_instruction", k), instruction_out, rom_word(vecs[k].e_ipc));
        end

        // PC wrap at the top of the address space.
        drive(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0, 16'h0);
        idle();
        chk("wrap_addr_fffe", 32'(read_addr), 32'h0000FFFE);
        idle();
        chk("wrap_addr_ffff", 32'(read_addr), 32'h0000FFFF);
        chk("wrap_ipc_fffe", 32'(inst_pc), 32'h0000FFFE);
        idle();
        chk("wrap_addr_0000", 32'(read_addr), 32'h00000000);
        chk("wrap_ipc_ffff", 32'(inst_pc), 32'h0000FFFF);
        idle();
        chk("wrap_addr_0001", 32'(read_addr), 32'h00000001);
        chk("wrap_ipc_0000", 32'(inst_pc), 32'h00000000);
        chk("wrap_vld", 32'(inst_valid), 32'd1);

        // loop_count = 1 must not arm; fetch stays linear.
        drive(1'b1, 1'b0, 1'b1, 16'h0080, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0081, 16'd1);
        chk("cnt1_addr_80", 32'(read_addr), 32'h80);
        idle();
        chk("cnt1_addr_81", 32'(read_addr), 32'h81);
        chk("cnt1_loop_active", 32'(loop_active), 32'd0);
        idle();
        chk("cnt1_addr_82", 32'(read_addr), 32'h82);
        chk("cnt1_loop_active2", 32'(loop_active), 32'd0);

        // Reset in the middle of an armed loop.
`ifdef FETCH_HWLOOP_EN
        la_exp = 1'b1;
`else
        la_exp = 1'b0;
`endif
        drive(1'b1, 1'b0, 1'b1, 16'h0090, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0091, 16'd5);
        chk("mrst_addr_90", 32'(read_addr), 32'h90);
        idle();
        chk("mrst_addr_91", 32'(read_addr), 32'h91);
        chk("mrst_loop_armed", 32'(loop_active), 32'(la_exp));
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        chk("mrst_read_en", 32'(read_en), 32'd0);
        idle();
        chk("mrst_addr_reset", 32'(read_addr), 32'(RST_PC));
        chk("mrst_vld", 32'(inst_valid), 32'd0);
        chk("mrst_ipc", 32'(inst_pc), 32'd0);
        chk("mrst_loop_active", 32'(loop_active), 32'd0);
        idle();
        chk("mrst_addr_next", 32'(read_addr), 32'(RST_PC + 16'd1));
        chk("mrst_vld_next", 32'(inst_valid), 32'd1);
        chk("mrst_ipc_next", 32'(inst_pc), 32'(RST_PC));
        chk("mrst_instr_next", instruction_out, rom_word(RST_PC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
